// File: rtl/player_action_seq.sv
// Player animation/action sequencer: decodes the held key on each frame tick and steps
// the walk / attack / cooldown animation, producing frame index and movement requests.
module player_action_seq #(
   parameter logic [7:0] LEFT_KEY        = 8'h1c,
   parameter logic [7:0] RIGHT_KEY       = 8'h23,
   parameter logic [7:0] ATTACK_KEY      = 8'h24,
   parameter int         FRAME_HOLD      = 3,
   parameter int         COOLDOWN_FRAMES = 6
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       press,
   input  logic [7:0] keycode,
   output logic [9:0] action,
   output logic [9:0] direction,
   output logic       move_left,
   output logic       move_right,
   output logic       attack_active,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WALK   = 2'd1;
   localparam logic [1:0] S_ATTACK = 2'd2;
   localparam logic [1:0] S_COOL   = 2'd3;

   localparam logic [3:0] HOLD_LAST = 4'(FRAME_HOLD - 1);
   localparam logic [5:0] COOL_LAST = 6'(COOLDOWN_FRAMES - 1);

   localparam logic [9:0] ACT_IDLE     = 10'd9;
   localparam logic [9:0] ACT_WALK_END = 10'd7;
   localparam logic [9:0] ACT_ATK_FST  = 10'd10;
   localparam logic [9:0] ACT_ATK_LST  = 10'd13;

   logic       frame_clk_q;
   logic       tick;
   logic [1:0] state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic [5:0] cool_q, cool_d;
   logic [9:0] action_q, action_d;
   logic       dir_q, dir_d;
   logic       move_left_q, move_left_d;
   logic       move_right_q, move_right_d;
   logic       attack_active_q, attack_active_d;
   logic       busy_q, busy_d;

   logic key_att, key_left, key_right, same_dir;

   assign tick = frame_clk & ~frame_clk_q;

   // Only one key is ever considered valid; attack wins, then left, then right.
   assign key_att   = press && (keycode == ATTACK_KEY);
   assign key_left  = press && (keycode == LEFT_KEY) && !key_att;
   assign key_right = press && (keycode == RIGHT_KEY) && !key_att && !key_left;
   assign same_dir  = (key_left && !dir_q) || (key_right && dir_q);

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      cool_d       = cool_q;
      action_d     = action_q;
      dir_d        = dir_q;
      move_left_d  = move_left_q;
      move_right_d = move_right_q;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (key_att) begin
                  state_d  = S_ATTACK;
                  action_d = ACT_ATK_FST;
                  hold_d   = 4'd0;
               end else if (key_left || key_right) begin
                  state_d      = S_WALK;
                  action_d     = 10'd0;
                  hold_d       = 4'd0;
                  dir_d        = key_right;
                  move_left_d  = key_left;
                  move_right_d = key_right;
               end else begin
                  action_d = ACT_IDLE;
               end
            end
            S_WALK: begin
               if (key_att) begin
                  state_d      = S_ATTACK;
                  action_d     = ACT_ATK_FST;
                  hold_d       = 4'd0;
                  move_left_d  = 1'b0;
                  move_right_d = 1'b0;
               end else if (same_dir) begin
                  move_left_d  = !dir_q;
                  move_right_d = dir_q;
                  if (hold_q == HOLD_LAST) begin
                     hold_d   = 4'd0;
                     action_d = (action_q == ACT_WALK_END) ? 10'd0 : action_q + 10'd1;
                  end else begin
                     hold_d = hold_q + 4'd1;
                  end
               end else if (key_left || key_right) begin
                  // Reversal restarts the walk cycle facing the new way in the same tick.
                  dir_d        = key_right;
                  action_d     = 10'd0;
                  hold_d       = 4'd0;
                  move_left_d  = key_left;
                  move_right_d = key_right;
               end else begin
                  state_d      = S_IDLE;
                  action_d     = ACT_IDLE;
                  hold_d       = 4'd0;
                  move_left_d  = 1'b0;
                  move_right_d = 1'b0;
               end
            end
            S_ATTACK: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = 4'd0;
                  if (action_q == ACT_ATK_LST) begin
                     state_d  = S_COOL;
                     action_d = ACT_IDLE;
                     cool_d   = 6'd0;
                  end else begin
                     action_d = action_q + 10'd1;
                  end
               end else begin
                  hold_d = hold_q + 4'd1;
               end
            end
            default: begin
               action_d     = ACT_IDLE;
               move_left_d  = 1'b0;
               move_right_d = 1'b0;
               if (cool_q == COOL_LAST) begin
                  state_d = S_IDLE;
                  cool_d  = 6'd0;
               end else begin
                  cool_d = cool_q + 6'd1;
               end
            end
         endcase
      end
      attack_active_d = (state_d == S_ATTACK) &&
                        ((action_d == 10'd11) || (action_d == 10'd12));
      busy_d          = (state_d == S_ATTACK) || (state_d == S_COOL);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_q     <= 1'b0;
         state_q         <= S_IDLE;
         hold_q          <= 4'd0;
         cool_q          <= 6'd0;
         action_q        <= ACT_IDLE;
         dir_q           <= 1'b1;
         move_left_q     <= 1'b0;
         move_right_q    <= 1'b0;
         attack_active_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         frame_clk_q     <= frame_clk;
         state_q         <= state_d;
         hold_q          <= hold_d;
         cool_q          <= cool_d;
         action_q        <= action_d;
         dir_q           <= dir_d;
         move_left_q     <= move_left_d;
         move_right_q    <= move_right_d;
         attack_active_q <= attack_active_d;
         busy_q          <= busy_d;
      end
   end

   assign action        = action_q;
   assign direction     = {9'd0, dir_q};
   assign move_left     = move_left_q;
   assign move_right    = move_right_q;
   assign attack_active = attack_active_q;
   assign busy          = busy_q;
   assign state_dbg     = state_q;

endmodule

// File: doc/player_action_seq.md
PLAYER_ACTION_SEQ -- requirements
Module: player_action_seq

Interface
REQ-001 Parameter LEFT_KEY, default 8'h1c, keycode for walk-left.
REQ-002 Parameter RIGHT_KEY, default 8'h23, keycode for walk-right.
REQ-003 Parameter ATTACK_KEY, default 8'h24, keycode for attack.
REQ-004 Parameter FRAME_HOLD, default 3, frame ticks per animation step (range 1..15).
REQ-005 Parameter COOLDOWN_FRAMES, default 6, frame ticks spent in COOLDOWN (range 1..63).
REQ-006 Clk  input  1  system clock; single clock domain.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 frame_clk  input  1  vertical-sync frame clock, synchronous to Clk, high for at least 2 Clk cycles.
REQ-009 press  input  1  1 = keycode currently held.
REQ-010 keycode  input  8  current keyboard scancode.
REQ-011 action  output  10  animation frame index: 9 idle, 0..7 walk, 10..13 attack.
REQ-012 direction  output  10  1 facing right, 0 facing left.
REQ-013 move_left  output  1  request player datapath to step left this frame.
REQ-014 move_right  output  1  request player datapath to step right this frame.
REQ-015 attack_active  output  1  hit window; opponent hit detection enabled.
REQ-016 busy  output  1  high in ATTACK or COOLDOWN; movement and attack input locked out.

Function
REQ-017 Tick: frame_clk registered once in Clk; tick = frame_clk & ~frame_clk_q, asserted for exactly one Clk cycle per frame_clk rising edge.
REQ-018 All state, counters and outputs are registered and change only on the Clk edge where tick=1; outputs are otherwise held.
REQ-019 Key decode: key X valid only if press=1 and keycode==X; priority ATTACK_KEY > LEFT_KEY > RIGHT_KEY.
REQ-020 States: IDLE, WALK, ATTACK, COOLDOWN; 4-bit hold counter and 6-bit cooldown counter.
REQ-021 IDLE on tick: attack -> ATTACK, action=10, hold=0; left/right -> WALK, action=0, hold=0, direction=0/1; none -> stay, action=9.
REQ-022 WALK on tick, attack -> ATTACK, action=10, hold=0, move_left/move_right=0.
REQ-023 WALK on tick, same direction key held: move output for that direction =1; hold increments; at hold==FRAME_HOLD-1, hold=0 and action advances 0..7, 7 wraps to 0.
REQ-024 WALK on tick, opposite direction key: direction flips, action=0, hold=0, move output switches to new direction in same tick.
REQ-025 WALK on tick, no valid key: -> IDLE, action=9, move outputs=0, hold=0.
REQ-026 ATTACK: keys ignored; action advances 10..13, each step held FRAME_HOLD ticks; after 13 held FRAME_HOLD ticks -> COOLDOWN, action=9, cooldown=0.
REQ-027 attack_active=1 exactly while action is 11 or 12 in ATTACK; 0 elsewhere.
REQ-028 COOLDOWN: keys ignored, action=9, move outputs=0; cooldown increments per tick; at COOLDOWN_FRAMES-1 -> IDLE on that tick.
REQ-029 Direction is retained through ATTACK, COOLDOWN and IDLE; changes only per REQ-021/REQ-024.
REQ-030 move_left and move_right are never simultaneously 1.
REQ-031 Keycode change between ticks has no effect; only value sampled at tick matters.

Reset
REQ-032 Reset=1 at any Clk edge, regardless of tick or state (including mid-ATTACK): state=IDLE, action=9, direction=1, move_left=0, move_right=0, attack_active=0, busy=0, hold=0, cooldown=0, frame_clk_q=0.
REQ-033 Reset overrides a coincident tick; first tick after Reset deassertion is processed from IDLE.

Verification
REQ-034 Reset, then RIGHT_KEY held for 25 ticks (FRAME_HOLD=3) -> tick1 action=0, move_right=1, direction=1; action increments every 3 ticks, wraps 7->0 at tick 25.
REQ-035 WALK right at action=4, LEFT_KEY at next tick -> direction=0, action=0, move_left=1, move_right=0 on that tick.
REQ-036 IDLE, ATTACK_KEY one tick then released -> actions 10,11,12,13 each 3 ticks, attack_active high ticks 4..9, then 6 ticks COOLDOWN with busy=1, then IDLE, busy=0.
REQ-037 Keys LEFT_KEY and ATTACK_KEY pressed during ATTACK and COOLDOWN -> no state/action change, move outputs stay 0.
REQ-038 Reset asserted mid-ATTACK coincident with tick -> all outputs at reset values next cycle; direction returns to 1.
REQ-039 press=0 with keycode=RIGHT_KEY in WALK -> IDLE, action=9, move_right=0.
